// File: rtl/e1_byte_serializer_pkg.sv
// Shared constants and types for the E1 byte serializer.
// Widths of the FIFO entry fields and the serializer state encoding live here.
// Bit order on the serial side is MSB-first.
package e1_byte_serializer_pkg;

  localparam int E1N_DEF = 7;   // number of E1 tributaries
  localparam int E1W_DEF = 3;   // channel number width
  localparam int IAW_DEF = 4;   // input FIFO address width
  localparam int DAT_W   = 8;   // data field width of an entry
  localparam int NB_W    = 4;   // valid-bit count field width of an entry

  // The bit on the wire is always the top bit of the shift register.
  localparam int MSB_BIT = DAT_W - 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

  // Oversize bit counts are shortened to a full byte before storage.
  function automatic logic [NB_W-1:0] clamp_nb(input logic [NB_W-1:0] nb);
    return (nb > NB_W'(DAT_W)) ? NB_W'(DAT_W) : nb;
  endfunction

endpackage

// File: rtl/e1_byte_serializer_if.sv
// Byte-wide tributary input bus of the serializer.
// Master offers Byte_DV/Cha/Dat/Nb; slave answers with Byte_Rdy.
// A byte moves when CE & Byte_DV & Byte_Rdy.
interface e1_byte_serializer_if #(
  parameter int E1W = e1_byte_serializer_pkg::E1W_DEF
) ();
  import e1_byte_serializer_pkg::*;

  logic             Byte_DV;
  logic [E1W-1:0]   Byte_Cha;
  logic [DAT_W-1:0] Byte_Dat;
  logic [NB_W-1:0]  Byte_Nb;
  logic             Byte_Rdy;

  modport master (output Byte_DV, Byte_Cha, Byte_Dat, Byte_Nb, input Byte_Rdy);
  modport slave  (input Byte_DV, Byte_Cha, Byte_Dat, Byte_Nb, output Byte_Rdy);

endinterface

// File: rtl/e1_byte_fifo.sv
// Single-clock CE-gated FIFO holding serializer input entries, with occupancy count.
// Latency: a pushed entry is readable (first-word fall-through) from the next CE cycle.
// Backpressure: none generated here; pushes into a full FIFO are ignored.
module e1_byte_fifo #(
  parameter int W  = 15,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic [AW:0]  fill,
  output logic [AW:0]  fill_nxt
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          do_push, do_pop;

  // Pointer and occupancy update; nothing moves outside CE cycles.
  always_comb begin
    do_push  = ce & push & (fill_q != (AW+1)'(DEPTH));
    do_pop   = ce & pop & (fill_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array; stale contents are never read because fill gates the reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat   = mem_q[rd_ptr_q];
  assign empty    = (fill_q == '0);
  assign fill     = fill_q;
  assign fill_nxt = fill_d;

endmodule

// File: rtl/e1_byte_serializer.sv
// Buffers tagged E1 tributary bytes and emits them MSB-first, one bit per CE cycle.
// Latency: byte accepted in CE cycle n -> first bit valid in CE cycle n+2; back-to-back bytes stream without gaps.
// Backpressure: Byte_Rdy (registered) drops at Fill = 2**IAW-1; bytes offered while low are dropped and flagged in Ovf.
module e1_byte_serializer
  import e1_byte_serializer_pkg::*;
#(
  parameter int E1N = E1N_DEF,
  parameter int E1W = E1W_DEF,
  parameter int IAW = IAW_DEF
) (
  input  logic                Ck,
  input  logic                Rs,
  input  logic                CE,
  e1_byte_serializer_if.slave byte_if,
  input  logic                Ovf_Clr,
  output logic                Mux_E1_DV,
  output logic [E1W-1:0]      Mux_E1_Cha,
  output logic                Mux_E1_Dat,
  output logic                Ovf,
  output logic                Err,
  output logic [IAW:0]        Fill
);
  localparam int EW    = E1W + DAT_W + NB_W;
  localparam int DEPTH = 2 ** IAW;

  ser_state_e       state_q, state_d;
  logic [DAT_W-1:0] shift_q, shift_d;
  logic [NB_W-1:0]  cnt_q, cnt_d;
  logic [E1W-1:0]   cha_q, cha_d;
  logic [E1W-1:0]   cha_hold_q, cha_hold_d;
  logic             dat_hold_q, dat_hold_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept, cha_bad, nb_zero, nb_big, push, pop, empty;
  logic [EW-1:0]    wr_dat, rd_dat;
  logic [E1W-1:0]   rd_cha;
  logic [DAT_W-1:0] rd_byte;
  logic [NB_W-1:0]  rd_nb;
  logic [IAW:0]     fifo_fill, fifo_fill_nxt;

  // Qualify the offered byte: Nb=0 and bad channels are not stored, oversize Nb is clamped.
  always_comb begin
    accept  = CE & byte_if.Byte_DV & rdy_q;
    cha_bad = 32'(byte_if.Byte_Cha) >= E1N;
    nb_zero = (byte_if.Byte_Nb == '0);
    nb_big  = (byte_if.Byte_Nb > NB_W'(DAT_W));
    push    = accept & ~cha_bad & ~nb_zero;
    wr_dat  = {byte_if.Byte_Cha, byte_if.Byte_Dat, clamp_nb(byte_if.Byte_Nb)};
  end

  e1_byte_fifo #(
    .W  (EW),
    .AW (IAW)
  ) u_fifo (
    .clk      (Ck),
    .rst      (Rs),
    .ce       (CE),
    .push     (push),
    .wr_dat   (wr_dat),
    .pop      (pop),
    .rd_dat   (rd_dat),
    .empty    (empty),
    .fill     (fifo_fill),
    .fill_nxt (fifo_fill_nxt)
  );

  assign {rd_cha, rd_byte, rd_nb} = rd_dat;

  // Serializer next state: load from the FIFO when idle, reload on the last bit to avoid gaps.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    cha_d      = cha_q;
    dat_hold_d = dat_hold_q;
    cha_hold_d = cha_hold_q;
    pop        = 1'b0;
    if (CE) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = rd_byte;
            cnt_d   = rd_nb;
            cha_d   = rd_cha;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          dat_hold_d = shift_q[MSB_BIT];
          cha_hold_d = cha_q;
          shift_d    = {shift_q[DAT_W-2:0], 1'b0};
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == NB_W'(1)) begin
            if (!empty) begin
              pop     = 1'b1;
              shift_d = rd_byte;
              cnt_d   = rd_nb;
              cha_d   = rd_cha;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sticky flags and registered ready; a same-cycle set beats the clear.
  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    rdy_d = rdy_q;
    if (CE) begin
      if (Ovf_Clr) begin
        ovf_d = 1'b0;
        err_d = 1'b0;
      end
      if (byte_if.Byte_DV & ~rdy_q) ovf_d = 1'b1;
      if (accept & (cha_bad | nb_big)) err_d = 1'b1;
      rdy_d = 32'(fifo_fill_nxt) <= DEPTH - 2;
    end
  end

  // State registers with synchronous reset; reset discards any partial byte.
  always_ff @(posedge Ck) begin
    if (Rs) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      cha_q      <= '0;
      cha_hold_q <= '0;
      dat_hold_q <= 1'b0;
      rdy_q      <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      cha_q      <= cha_d;
      cha_hold_q <= cha_hold_d;
      dat_hold_q <= dat_hold_d;
      rdy_q      <= rdy_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign Mux_E1_DV        = (state_q == S_SHIFT);
  assign Mux_E1_Dat       = Mux_E1_DV ? shift_q[MSB_BIT] : dat_hold_q;
  assign Mux_E1_Cha       = Mux_E1_DV ? cha_q : cha_hold_q;
  assign byte_if.Byte_Rdy = rdy_q;
  assign Ovf              = ovf_q;
  assign Err              = err_q;
  assign Fill             = fifo_fill;

endmodule

// File: tb/tb_e1_byte_serializer.sv
// Bench for e1_byte_serializer: directed scenarios plus randomized traffic against a queue-based model.
module tb_e1_byte_serializer;
  localparam int TB_E1N   = 7;
  localparam int TB_E1W   = 3;
  localparam int TB_IAW   = 4;
  localparam int TB_DEPTH = 16;

  logic       Ck = 1'b0;
  logic       Rs = 1'b1;
  logic       CE = 1'b0;
  logic       Ovf_Clr = 1'b0;
  logic       Mux_E1_DV;
  logic [2:0] Mux_E1_Cha;
  logic       Mux_E1_Dat;
  logic       Ovf;
  logic       Err;
  logic [4:0] Fill;

  e1_byte_serializer_if #(.E1W(TB_E1W)) bif ();

  e1_byte_serializer #(
    .E1N (TB_E1N),
    .E1W (TB_E1W),
    .IAW (TB_IAW)
  ) dut (
    .Ck         (Ck),
    .Rs         (Rs),
    .CE         (CE),
    .byte_if    (bif),
    .Ovf_Clr    (Ovf_Clr),
    .Mux_E1_DV  (Mux_E1_DV),
    .Mux_E1_Cha (Mux_E1_Cha),
    .Mux_E1_Dat (Mux_E1_Dat),
    .Ovf        (Ovf),
    .Err        (Err),
    .Fill       (Fill)
  );

  always #5 Ck = ~Ck;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of stored bytes, a list of bits still to send for the
  // current byte, and sticky flags. Logs hold emitted bits as cha*2+bit.
  typedef struct { int cha; int dat; int nb; } ent_t;
  ent_t m_q[$];
  int   m_bits[$];
  int   m_cha, m_last_dat, m_last_cha;
  bit   m_rdy, m_ovf, m_err;
  int   m_log[$];
  int   d_log[$];

  function automatic void load_byte();
    ent_t e;
    e = m_q.pop_front();
    m_cha = e.cha;
    for (int i = 0; i < e.nb; i++) m_bits.push_back((e.dat >> (7 - i)) & 1);
  endfunction

  task automatic model_step(input bit rs, input bit ce, input bit dv, input int cha,
                            input int dat, input int nb, input bit clr);
    bit was_rdy;
    ent_t e;
    if (rs) begin
      m_q.delete(); m_bits.delete();
      m_cha = 0; m_last_dat = 0; m_last_cha = 0;
      m_rdy = 0; m_ovf = 0; m_err = 0;
      return;
    end
    if (!ce) return;
    was_rdy = m_rdy;
    if (m_bits.size() > 0) begin
      m_last_dat = m_bits.pop_front();
      m_last_cha = m_cha;
      m_log.push_back(m_cha * 2 + m_last_dat);
      if (m_bits.size() == 0 && m_q.size() > 0) load_byte();
    end else if (m_q.size() > 0) begin
      load_byte();
    end
    if (clr) begin m_ovf = 0; m_err = 0; end
    if (dv && !was_rdy) m_ovf = 1;
    if (dv && was_rdy) begin
      if (cha >= TB_E1N || nb > 8) m_err = 1;
      if (cha < TB_E1N && nb != 0) begin
        e.cha = cha; e.dat = dat; e.nb = (nb > 8) ? 8 : nb;
        m_q.push_back(e);
      end
    end
    m_rdy = (m_q.size() <= TB_DEPTH - 2);
  endtask

  function automatic logic [12:0] m_vec();
    logic       dv;
    logic       d;
    logic [2:0] c;
    dv = (m_bits.size() > 0);
    d  = dv ? 1'(m_bits[0]) : 1'(m_last_dat);
    c  = dv ? 3'(m_cha) : 3'(m_last_cha);
    return {dv, d, c, 5'(m_q.size()), m_rdy, m_ovf, m_err};
  endfunction

  function automatic logic [12:0] d_vec();
    return {Mux_E1_DV, Mux_E1_Dat, Mux_E1_Cha, Fill, bif.Byte_Rdy, Ovf, Err};
  endfunction

  function automatic bit logs_equal();
    if (d_log.size() != m_log.size()) return 0;
    foreach (d_log[i]) if (d_log[i] != m_log[i]) return 0;
    return 1;
  endfunction

  // One Ck cycle: drive in the low phase, log a DUT bit if it is consumed, step the model.
  task automatic drive(input bit ce, input bit dv, input int cha, input int dat,
                       input int nb, input bit clr, input bit rs);
    CE = ce; Rs = rs; Ovf_Clr = clr;
    bif.Byte_DV = dv; bif.Byte_Cha = 3'(cha); bif.Byte_Dat = 8'(dat); bif.Byte_Nb = 4'(nb);
    #1;
    if (ce && !rs && Mux_E1_DV === 1'b1) d_log.push_back(int'(Mux_E1_Cha) * 2 + int'(Mux_E1_Dat));
    @(posedge Ck);
    model_step(rs, ce, dv, cha, dat, nb, clr);
    @(negedge Ck);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (m_bits.size() > 0 || m_q.size() > 0); i++) idle(1);
    idle(2);
  endtask

  task automatic test_reset();
    repeat (3) drive(1, 1, 2, 8'hFF, 8, 0, 1);
    n_chk++;
    if (d_vec() !== 13'd0) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", d_vec(), 13'd0);
    end
    idle(1);
    n_chk++;
    if (bif.Byte_Rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy: got %b want 1", bif.Byte_Rdy);
    end
  endtask

  task automatic test_single();
    int exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    drive(1, 1, 2, 8'hA5, 8, 0, 0);
    n_chk++;
    if (Mux_E1_DV !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: DV at n+1 got %b want 0", Mux_E1_DV);
    end
    idle(1);
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if ({Mux_E1_DV, Mux_E1_Cha, Mux_E1_Dat} !== {1'b1, 3'd2, 1'(exp_bits[i])}) begin
        n_fail++;
        $display("FAIL single_bit%0d: got dv=%b cha=%0d dat=%b want dv=1 cha=2 dat=%0d",
                 i, Mux_E1_DV, Mux_E1_Cha, Mux_E1_Dat, exp_bits[i]);
      end
      idle(1);
    end
    n_chk++;
    if (Mux_E1_DV !== 1'b0) begin
      n_fail++; $display("FAIL single_end: DV got %b want 0", Mux_E1_DV);
    end
  endtask

  task automatic test_back_to_back();
    int exp_cha[3] = '{1, 1, 3};
    drive(1, 1, 1, 8'hC0, 2, 0, 0);
    drive(1, 1, 3, 8'hFF, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({Mux_E1_DV, Mux_E1_Cha, Mux_E1_Dat} !== {1'b1, 3'(exp_cha[i]), 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: got dv=%b cha=%0d dat=%b want dv=1 cha=%0d dat=1",
                 i, Mux_E1_DV, Mux_E1_Cha, Mux_E1_Dat, exp_cha[i]);
      end
      idle(1);
    end
    n_chk++;
    if (Mux_E1_DV !== 1'b0 || Mux_E1_Cha !== 3'd3 || Mux_E1_Dat !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold: got dv=%b cha=%0d dat=%b want dv=0 cha=3 dat=1",
               Mux_E1_DV, Mux_E1_Cha, Mux_E1_Dat);
    end
  endtask

  task automatic test_ce_toggle();
    int dat;
    int exp;
    bit ok;
    dat = $urandom_range(0, 255);
    d_log.delete(); m_log.delete();
    drive(1, 1, 5, dat, 4, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(i % 2 == 1, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (d_vec() !== m_vec()) begin
        n_fail++; $display("FAIL ce_cycle%0d: got %b want %b", i, d_vec(), m_vec());
      end
    end
    ok = (d_log.size() == 4);
    for (int i = 0; i < 4 && ok; i++) begin
      exp = 5 * 2 + ((dat >> (7 - i)) & 1);
      if (d_log[i] != exp) ok = 0;
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL ce_bits: got %0d bits want 4 bits of dat=%02h", d_log.size(), dat);
    end
  endtask

  task automatic test_overflow();
    int max_fill;
    max_fill = 0;
    d_log.delete(); m_log.delete();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, $urandom_range(0, 6), $urandom_range(0, 255), 8, 0, 0);
      n_chk++;
      if (d_vec() !== m_vec()) begin
        n_fail++; $display("FAIL ovf_cycle%0d: got %b want %b", i, d_vec(), m_vec());
      end
      if (int'(Fill) > max_fill) max_fill = int'(Fill);
    end
    n_chk++;
    if (max_fill != 15) begin
      n_fail++; $display("FAIL ovf_max_fill: got %0d want 15", max_fill);
    end
    n_chk++;
    if (Ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %b want 1", Ovf);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    n_chk++;
    if (Ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", Ovf);
    end
    drain();
    n_chk++;
    if (!logs_equal()) begin
      n_fail++; $display("FAIL ovf_stream: got %0d bits want %0d", d_log.size(), m_log.size());
    end
  endtask

  task automatic test_bad_input();
    int dat;
    bit ok;
    dat = $urandom_range(0, 255);
    d_log.delete(); m_log.delete();
    drive(1, 1, 1, dat, 0, 0, 0);
    idle(12);
    n_chk++;
    if (d_log.size() != 0 || Err !== 1'b0) begin
      n_fail++; $display("FAIL nb0: got bits=%0d err=%b want bits=0 err=0", d_log.size(), Err);
    end
    drive(1, 1, 4, dat, 12, 0, 0);
    idle(12);
    n_chk++;
    if (Err !== 1'b1) begin
      n_fail++; $display("FAIL nb12_err: got %b want 1", Err);
    end
    ok = (d_log.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (d_log[i] != 4 * 2 + ((dat >> (7 - i)) & 1)) ok = 0;
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL nb12_bits: got %0d bits want 8 of dat=%02h on ch4", d_log.size(), dat);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    n_chk++;
    if (Err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", Err);
    end
    d_log.delete(); m_log.delete();
    drive(1, 1, 7, dat, 8, 0, 0);
    idle(12);
    n_chk++;
    if (d_log.size() != 0 || Err !== 1'b1 || Fill !== 5'd0) begin
      n_fail++;
      $display("FAIL bad_cha: got bits=%0d err=%b fill=%0d want bits=0 err=1 fill=0",
               d_log.size(), Err, Fill);
    end
  endtask

  task automatic test_reset_mid();
    d_log.delete(); m_log.delete();
    for (int i = 0; i < 3; i++) drive(1, 1, i, $urandom_range(0, 255), 8, 0, 0);
    for (int i = 0; i < 20 && d_log.size() < 3; i++) idle(1);
    n_chk++;
    if (d_log.size() != 3) begin
      n_fail++; $display("FAIL rstmid_pre: got %0d bits want 3", d_log.size());
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (Mux_E1_DV !== 1'b0 || Fill !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_after: got dv=%b fill=%0d want dv=0 fill=0", Mux_E1_DV, Fill);
    end
    idle(12);
    n_chk++;
    if (d_log.size() != 3 || !logs_equal()) begin
      n_fail++; $display("FAIL rstmid_residual: got %0d bits want 3", d_log.size());
    end
  endtask

  task automatic test_random();
    d_log.delete(); m_log.delete();
    for (int i = 0; i < 600; i++) begin
      bit ce;
      bit dv;
      bit clr;
      int nb;
      ce  = ($urandom_range(0, 4) != 0);
      dv  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      nb  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
      drive(ce, dv, $urandom_range(0, 7), $urandom_range(0, 255), nb, clr, 0);
      n_chk++;
      if (d_vec() !== m_vec()) begin
        n_fail++; $display("FAIL rand_cycle%0d: got %b want %b", i, d_vec(), m_vec());
      end
    end
    drain();
    n_chk++;
    if (!logs_equal()) begin
      n_fail++; $display("FAIL rand_stream: got %0d bits want %0d", d_log.size(), m_log.size());
    end
  endtask

  initial begin
    bif.Byte_DV = 1'b0; bif.Byte_Cha = '0; bif.Byte_Dat = '0; bif.Byte_Nb = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ce_toggle();
    test_overflow();
    test_bad_input();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
